// File: rtl/multicycle_control_if.sv
// Bus between the multicycle controller and its datapath/memory side.
// Memory handshake: mem_req is the valid, mem_ready the ready. A request
// completes in the cycle both are high; until then the controller holds
// mem_req and its qualifiers (mem_we, mem_fetch, mem_size, mem_unsigned)
// stable. mem_ready seen while mem_req is low has no effect.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       mem_ready;
  logic       branch_taken;
  logic       mem_req;
  logic       mem_we;
  logic       mem_fetch;
  logic [1:0] mem_size;
  logic       mem_unsigned;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic [1:0] alu_op;
  logic       alu_src;
  logic       reg_write;
  logic       mem_to_reg;
  logic       lui;
  logic       auipc;
  logic       jal;
  logic       jalr;
  logic       branch;
  logic       instr_retired;
  logic       illegal;
  logic       bus_error;
  logic [2:0] state;

  // Controller side
  modport master (
    input  opcode, funct3, mem_ready, branch_taken,
    output mem_req, mem_we, mem_fetch, mem_size, mem_unsigned, ir_write,
           pc_write, pc_src, alu_op, alu_src, reg_write, mem_to_reg, lui,
           auipc, jal, jalr, branch, instr_retired, illegal, bus_error, state
  );

  // Datapath / memory side
  modport slave (
    output opcode, funct3, mem_ready, branch_taken,
    input  mem_req, mem_we, mem_fetch, mem_size, mem_unsigned, ir_write,
           pc_write, pc_src, alu_op, alu_src, reg_write, mem_to_reg, lui,
           auipc, jal, jalr, branch, instr_retired, illegal, bus_error, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I-style control FSM: FETCH, DECODE, EXECUTE, MEMORY,
// WRITEBACK and a sticky TRAP. Instruction class and funct3 are captured in
// DECODE; all later outputs come from those registers, never from the
// live opcode/funct3 inputs. Memory waits are bounded by MEM_TIMEOUT.
module multicycle_control #(
  parameter int MEM_TIMEOUT  = 16,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  multicycle_control_if.master bus
);

  // Zero timeout still needs a 1-bit counter so the declarations stay legal.
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST_WAIT = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    C_ILLEGAL = 4'd0,
    C_R       = 4'd1,
    C_I       = 4'd2,
    C_LOAD    = 4'd3,
    C_STORE   = 4'd4,
    C_BRANCH  = 4'd5,
    C_JAL     = 4'd6,
    C_JALR    = 4'd7,
    C_LUI     = 4'd8,
    C_AUIPC   = 4'd9
  } class_e;

  state_e        state_q, state_d;
  class_e        cls_q, cls_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d;
  logic          bus_error_q, bus_error_d;

  logic          wait_expired;
  logic [CW-1:0] cnt_inc;

  // Opcode/funct3 classification, including the reserved funct3 encodings.
  function automatic class_e classify(input logic [6:0] op, input logic [2:0] f3);
    class_e c;
    case (op)
      7'b0110011: c = C_R;
      7'b0010011: c = C_I;
      7'b0000011: c = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? C_ILLEGAL : C_LOAD;
      7'b0100011: c = (f3 > 3'd2) ? C_ILLEGAL : C_STORE;
      7'b1100011: c = (f3 == 3'd2 || f3 == 3'd3) ? C_ILLEGAL : C_BRANCH;
      7'b1101111: c = C_JAL;
      7'b1100111: c = (f3 != 3'd0) ? C_ILLEGAL : C_JALR;
      7'b0110111: c = C_LUI;
      7'b0010111: c = C_AUIPC;
      default:    c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  // The waiting cycle that carries count LAST_WAIT is the final one allowed.
  assign wait_expired = (MEM_TIMEOUT != 0) && (cnt_q == LAST_WAIT);
  assign cnt_inc      = (MEM_TIMEOUT != 0) ? cnt_q + 1'b1 : '0;

  // Next-state logic; the wait counter is zero on every path except a
  // continued wait, so it is clear on each entry to FETCH or MEMORY.
  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    funct3_d    = funct3_q;
    cnt_d       = '0;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DECODE: begin
        cls_d    = classify(bus.opcode, bus.funct3);
        funct3_d = bus.funct3;
        if (cls_d == C_ILLEGAL && TRAP_ILLEGAL) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (cls_q)
          C_BRANCH:       state_d = S_FETCH;
          C_LOAD, C_STORE: state_d = S_MEMORY;
          default:        state_d = S_WRITEBACK;
        endcase
      end
      S_MEMORY: begin
        if (bus.mem_ready) begin
          state_d = (cls_q == C_LOAD) ? S_WRITEBACK : S_FETCH;
        end else if (wait_expired) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_TRAP;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      cls_q       <= C_ILLEGAL;
      funct3_q    <= 3'd0;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      funct3_q    <= funct3_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Output decode from state and registered class; all zero while in reset.
  always_comb begin
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_fetch     = 1'b0;
    bus.mem_size      = 2'b00;
    bus.mem_unsigned  = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_src        = 2'b00;
    bus.alu_op        = 2'b00;
    bus.alu_src       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.lui           = 1'b0;
    bus.auipc         = 1'b0;
    bus.jal           = 1'b0;
    bus.jalr          = 1'b0;
    bus.branch        = 1'b0;
    bus.instr_retired = 1'b0;
    bus.illegal       = 1'b0;
    bus.bus_error     = 1'b0;
    bus.state         = 3'd0;
    if (rst_n) begin
      bus.state     = state_q;
      bus.illegal   = illegal_q;
      bus.bus_error = bus_error_q;
      // Datapath selects are held from EXECUTE through WRITEBACK.
      if (state_q == S_EXECUTE || state_q == S_WRITEBACK) begin
        case (cls_q)
          C_R:     bus.alu_op = 2'b10;
          C_I:     begin bus.alu_op = 2'b10; bus.alu_src = 1'b1; end
          C_LOAD,
          C_STORE: begin bus.alu_op = 2'b00; bus.alu_src = 1'b1; end
          C_BRANCH: begin bus.alu_op = 2'b01; bus.branch = 1'b1; end
          C_JALR:  begin bus.alu_src = 1'b1; bus.jalr = 1'b1; end
          C_JAL:   bus.jal = 1'b1;
          C_LUI:   bus.lui = 1'b1;
          C_AUIPC: begin bus.auipc = 1'b1; bus.alu_src = 1'b1; end
          default: ;
        endcase
      end
      case (state_q)
        S_FETCH: begin
          bus.mem_req   = 1'b1;
          bus.mem_fetch = 1'b1;
          bus.mem_size  = 2'b10;
          bus.ir_write  = bus.mem_ready;
        end
        S_EXECUTE: begin
          if (cls_q == C_BRANCH) begin
            bus.pc_write      = 1'b1;
            bus.pc_src        = bus.branch_taken ? 2'b01 : 2'b00;
            bus.instr_retired = 1'b1;
          end
        end
        S_MEMORY: begin
          bus.mem_req      = 1'b1;
          bus.mem_we       = (cls_q == C_STORE);
          bus.mem_size     = funct3_q[1:0];
          bus.mem_unsigned = funct3_q[2] & (cls_q == C_LOAD);
          if (bus.mem_ready && cls_q == C_STORE) begin
            bus.pc_write      = 1'b1;
            bus.instr_retired = 1'b1;
          end
        end
        S_WRITEBACK: begin
          bus.reg_write     = (cls_q != C_ILLEGAL);
          bus.mem_to_reg    = (cls_q == C_LOAD);
          bus.pc_write      = 1'b1;
          bus.instr_retired = 1'b1;
          bus.pc_src        = (cls_q == C_JAL)  ? 2'b01 :
                              (cls_q == C_JALR) ? 2'b10 : 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Two instances: A with the default timeout
// and illegal trapping, B with MEM_TIMEOUT=4 and illegal-as-NOP. A reference
// model expands each instruction into its expected per-cycle output trace
// and the stimulus to apply on each of those cycles.
module tb_multicycle_control;

  localparam int A_TMO = 16;
  localparam int B_TMO = 4;
  localparam int TRAP_HOLD = 10;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       mem_fetch;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       lui;
    logic       auipc;
    logic       jal;
    logic       jalr;
    logic       branch;
    logic       instr_retired;
    logic       illegal;
    logic       bus_error;
  } obs_t;

  localparam int W = $bits(obs_t);

  typedef struct packed {
    logic       rdy;
    logic       taken;
    logic [6:0] opc;
    logic [2:0] f3;
  } drv_t;

  typedef enum {K_ILL, K_R, K_I, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR, K_LUI, K_AUIPC} kind_e;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if ifc_a ();
  multicycle_control_if ifc_b ();

  multicycle_control #(.MEM_TIMEOUT(A_TMO), .TRAP_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifc_a.master)
  );
  multicycle_control #(.MEM_TIMEOUT(B_TMO), .TRAP_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifc_b.master)
  );

  obs_t obs_a, obs_b;
  assign obs_a = {ifc_a.state, ifc_a.mem_req, ifc_a.mem_we, ifc_a.mem_fetch, ifc_a.mem_size,
                  ifc_a.mem_unsigned, ifc_a.ir_write, ifc_a.pc_write, ifc_a.pc_src, ifc_a.alu_op,
                  ifc_a.alu_src, ifc_a.reg_write, ifc_a.mem_to_reg, ifc_a.lui, ifc_a.auipc,
                  ifc_a.jal, ifc_a.jalr, ifc_a.branch, ifc_a.instr_retired, ifc_a.illegal,
                  ifc_a.bus_error};
  assign obs_b = {ifc_b.state, ifc_b.mem_req, ifc_b.mem_we, ifc_b.mem_fetch, ifc_b.mem_size,
                  ifc_b.mem_unsigned, ifc_b.ir_write, ifc_b.pc_write, ifc_b.pc_src, ifc_b.alu_op,
                  ifc_b.alu_src, ifc_b.reg_write, ifc_b.mem_to_reg, ifc_b.lui, ifc_b.auipc,
                  ifc_b.jal, ifc_b.jalr, ifc_b.branch, ifc_b.instr_retired, ifc_b.illegal,
                  ifc_b.bus_error};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  drv_t         drv_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic kind_e kind_of(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return (f3 inside {3'd3, 3'd6, 3'd7}) ? K_ILL : K_LOAD;
      7'b0100011: return (f3 > 3'd2) ? K_ILL : K_STORE;
      7'b1100011: return (f3 inside {3'd2, 3'd3}) ? K_ILL : K_BRANCH;
      7'b1101111: return K_JAL;
      7'b1100111: return (f3 != 3'd0) ? K_ILL : K_JALR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return K_ILL;
    endcase
  endfunction

  // Selects shown during EXECUTE and kept through WRITEBACK.
  function automatic obs_t exec_sel(input kind_e k);
    obs_t e;
    e = '0;
    case (k)
      K_R:      e.alu_op = 2'b10;
      K_I:      begin e.alu_op = 2'b10; e.alu_src = 1'b1; end
      K_LOAD,
      K_STORE:  e.alu_src = 1'b1;
      K_BRANCH: begin e.alu_op = 2'b01; e.branch = 1'b1; end
      K_JALR:   begin e.alu_src = 1'b1; e.jalr = 1'b1; end
      K_JAL:    e.jal = 1'b1;
      K_LUI:    e.lui = 1'b1;
      K_AUIPC:  begin e.auipc = 1'b1; e.alu_src = 1'b1; end
      default:  ;
    endcase
    return e;
  endfunction

  // Don't-care stimulus: inputs that must be ignored get random values.
  function automatic drv_t rand_drv();
    drv_t d;
    d.rdy   = 1'($urandom_range(0, 1));
    d.taken = 1'($urandom_range(0, 1));
    d.opc   = 7'($urandom_range(0, 127));
    d.f3    = 3'($urandom_range(0, 7));
    return d;
  endfunction

  function automatic void push(input obs_t e, input drv_t d);
    exp_q.push_back(e);
    drv_q.push_back(d);
  endfunction

  function automatic void push_trap(input logic ill, input logic bus);
    obs_t e;
    for (int i = 0; i < TRAP_HOLD; i++) begin
      e = '0;
      e.state = 3'd7;
      e.illegal = ill;
      e.bus_error = bus;
      push(e, rand_drv());
    end
  endfunction

  // Memory wait: ready arrives after `wait_n` idle cycles, unless the
  // timeout (tmo idle cycles) runs out first. Returns 1 on timeout.
  function automatic bit push_wait(input obs_t base, input obs_t on_ready, input int wait_n, input int tmo);
    obs_t e;
    drv_t d;
    for (int c = 0; c <= wait_n; c++) begin
      if (tmo != 0 && c == tmo) begin
        push_trap(1'b0, 1'b1);
        return 1'b1;
      end
      d = rand_drv();
      d.rdy = (c == wait_n);
      e = (c == wait_n) ? (base | on_ready) : base;
      push(e, d);
    end
    return 1'b0;
  endfunction

  // Expands one instruction into expected trace; returns 1 if it ends in TRAP.
  function automatic bit build(input logic [6:0] opc, input logic [2:0] f3, input logic taken,
                               input int fw, input int mw, input int tmo, input bit trap_ill);
    kind_e k;
    obs_t  e, r;
    drv_t  d;
    k = kind_of(opc, f3);
    e = '0; e.mem_req = 1'b1; e.mem_fetch = 1'b1; e.mem_size = 2'b10;
    r = '0; r.ir_write = 1'b1;
    if (push_wait(e, r, fw, tmo)) return 1'b1;
    e = '0; e.state = 3'd1;
    d = rand_drv(); d.opc = opc; d.f3 = f3;
    push(e, d);
    if (k == K_ILL && trap_ill) begin
      push_trap(1'b1, 1'b0);
      return 1'b1;
    end
    e = exec_sel(k); e.state = 3'd2;
    d = rand_drv(); d.taken = taken;
    if (k == K_BRANCH) begin
      e.pc_write = 1'b1; e.pc_src = taken ? 2'b01 : 2'b00; e.instr_retired = 1'b1;
      push(e, d);
      return 1'b0;
    end
    push(e, d);
    if (k == K_LOAD || k == K_STORE) begin
      e = '0; e.state = 3'd3; e.mem_req = 1'b1; e.mem_we = (k == K_STORE);
      e.mem_size = f3[1:0]; e.mem_unsigned = f3[2] & (k == K_LOAD);
      r = '0;
      if (k == K_STORE) begin r.pc_write = 1'b1; r.instr_retired = 1'b1; end
      if (push_wait(e, r, mw, tmo)) return 1'b1;
      if (k == K_STORE) return 1'b0;
    end
    e = exec_sel(k); e.state = 3'd4;
    e.reg_write = (k != K_ILL); e.mem_to_reg = (k == K_LOAD);
    e.pc_write = 1'b1; e.instr_retired = 1'b1;
    e.pc_src = (k == K_JAL) ? 2'b01 : (k == K_JALR) ? 2'b10 : 2'b00;
    push(e, rand_drv());
    return 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input drv_t d);
    if (sel == 0) begin
      ifc_a.mem_ready = d.rdy; ifc_a.branch_taken = d.taken;
      ifc_a.opcode = d.opc;    ifc_a.funct3 = d.f3;
    end else begin
      ifc_b.mem_ready = d.rdy; ifc_b.branch_taken = d.taken;
      ifc_b.opcode = d.opc;    ifc_b.funct3 = d.f3;
    end
  endtask

  // Called just after a rising edge; leaves time just after a rising edge.
  task automatic run(input int sel, input string tag, input int limit);
    int n;
    logic [W-1:0] exp;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      drive(sel, drv_q.pop_front());
      exp = exp_q.pop_front();
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, n), (sel == 0) ? obs_a : obs_b, exp);
      @(posedge clk); #1;
      n++;
    end
    exp_q.delete();
    drv_q.delete();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive(0, rand_drv());
      drive(1, rand_drv());
      @(negedge clk);
      check("reset_a", obs_a, '0);
      check("reset_b", obs_b, '0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic step(input int sel, input string tag, input logic [6:0] opc, input logic [2:0] f3,
                      input logic taken, input int fw, input int mw, output bit trapped);
    trapped = build(opc, f3, taken, fw, mw, (sel == 0) ? A_TMO : B_TMO, (sel == 0));
    run(sel, tag, 100000);
  endtask

  // ---------------- directed + random sequence ----------------
  logic [6:0] ops [0:9];
  bit tr;

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
    rst_n = 1'b0;
    drive(0, '0);
    drive(1, '0);
    do_reset(2);

    // Instance A: each class once, normal flow
    step(0, "add",        7'b0110011, 3'd0, 1'b0, 0, 0, tr);
    step(0, "lw",         7'b0000011, 3'd2, 1'b0, 1, 3, tr);
    step(0, "beq_taken",  7'b1100011, 3'd0, 1'b1, 0, 0, tr);
    step(0, "beq_not",    7'b1100011, 3'd0, 1'b0, 2, 0, tr);
    step(0, "lbu",        7'b0000011, 3'd4, 1'b0, 0, 0, tr);
    step(0, "sh",         7'b0100011, 3'd1, 1'b0, 0, 2, tr);
    step(0, "jal",        7'b1101111, 3'd5, 1'b0, 0, 0, tr);
    step(0, "jalr",       7'b1100111, 3'd0, 1'b0, 0, 0, tr);
    step(0, "lui",        7'b0110111, 3'd3, 1'b0, 0, 0, tr);
    step(0, "auipc",      7'b0010111, 3'd1, 1'b0, 0, 0, tr);
    step(0, "addi_fw15",  7'b0010011, 3'd0, 1'b0, 15, 0, tr);
    step(0, "illegal_a",  7'b1111111, 3'd0, 1'b0, 0, 0, tr);
    do_reset(1);
    step(0, "after_trap", 7'b0110011, 3'd0, 1'b0, 0, 0, tr);

    // Reset for one cycle during the MEMORY wait of a store
    void'(build(7'b0100011, 3'd2, 1'b0, 0, 5, A_TMO, 1'b1));
    run(0, "sw_abort", 4);
    do_reset(1);
    step(0, "after_abort", 7'b0110011, 3'd0, 1'b0, 0, 0, tr);

    // Instance B: illegal as NOP, timeout boundaries
    do_reset(1);
    step(1, "illegal_b",  7'b1111111, 3'd0, 1'b0, 0, 0, tr);
    step(1, "add_fw3",    7'b0110011, 3'd0, 1'b0, 3, 0, tr);
    step(1, "fetch_tmo",  7'b0110011, 3'd0, 1'b0, 4, 0, tr);
    do_reset(1);
    step(1, "lw_mw3",     7'b0000011, 3'd0, 1'b0, 0, 3, tr);
    step(1, "lw_tmo",     7'b0000011, 3'd5, 1'b0, 0, 4, tr);
    do_reset(1);

    // Random instruction streams
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 40; i++) begin
        int idx, fw, mw;
        logic [6:0] opc;
        idx = $urandom_range(0, 10);
        opc = (idx == 10) ? 7'($urandom_range(0, 127)) : ops[idx];
        if (s == 0) begin
          fw = ($urandom_range(0, 9) == 0) ? A_TMO : $urandom_range(0, 5);
          mw = ($urandom_range(0, 9) == 0) ? A_TMO : $urandom_range(0, 5);
        end else begin
          fw = $urandom_range(0, 5);
          mw = $urandom_range(0, 5);
        end
        step(s, (s == 0) ? "rand_a" : "rand_b", opc, 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), fw, mw, tr);
        if (tr) do_reset(1);
      end
      do_reset(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: maximum cycles to wait for mem_ready per access; 0 disables the timeout.
REQ-002 Parameter TRAP_ILLEGAL, default 1: 1 means an illegal encoding enters TRAP; 0 means it retires as a NOP.
REQ-003 Ports, clock and reset first:
  clk  in  1  single clock; all state changes on its rising edge.
  rst_n  in  1  reset, synchronous and active-low.
  opcode  in  7  instruction opcode from the instruction register.
  funct3  in  3  instruction funct3 from the instruction register.
  mem_ready  in  1  memory completes the current request this cycle.
  branch_taken  in  1  branch comparator result, valid in EXECUTE.
  mem_req  out  1  memory request.
  mem_we  out  1  write request (store).
  mem_fetch  out  1  request is an instruction fetch.
  mem_size  out  2  access width: 00 byte, 01 half, 10 word.
  mem_unsigned  out  1  load is zero-extended.
  ir_write  out  1  latch the instruction register.
  pc_write  out  1  update the PC.
  pc_src  out  2  PC source: 00 pc+4, 01 pc+imm, 10 jalr target.
  alu_op  out  2  ALU operation: 00 ADD, 01 SUB, 10 funct-decoded.
  alu_src  out  1  ALU operand B: 1 immediate, 0 rs2.
  reg_write, mem_to_reg, lui, auipc, jal, jalr, branch  out  1 each  datapath selects.
  instr_retired  out  1  one-cycle pulse per completed instruction.
  illegal  out  1  sticky: TRAP entered by illegal decode.
  bus_error  out  1  sticky: TRAP entered by memory timeout.
  state  out  3  current state, for debug.

Function
REQ-004 State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=7; codes 5 and 6 are unreachable and go to TRAP.
REQ-005 FETCH: assert mem_req=1, mem_fetch=1, mem_size=10; hold until mem_ready; in the mem_ready cycle assert ir_write=1 and go to DECODE.
REQ-006 DECODE (one cycle): classify opcode into R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC or ILLEGAL; register the class and funct3; go to EXECUTE, or to TRAP if ILLEGAL and TRAP_ILLEGAL=1.
REQ-007 After DECODE, outputs depend only on the registered class and funct3; changes on opcode and funct3 are ignored until the next DECODE.
REQ-008 ILLEGAL covers:
  - any unlisted opcode;
  - LOAD with funct3 in {3,6,7};
  - STORE with funct3>2;
  - BRANCH with funct3 in {2,3};
  - JALR with funct3!=0.
REQ-009 When TRAP_ILLEGAL=0, ILLEGAL goes EXECUTE -> WRITEBACK with reg_write=0, pc_write=1, pc_src=00.
REQ-010 EXECUTE (one cycle), per class:
  - R: alu_op=10, alu_src=0.
  - I: alu_op=10, alu_src=1.
  - LOAD/STORE: alu_op=00, alu_src=1.
  - BRANCH: alu_op=01, branch=1.
  - JALR: alu_src=1, jalr=1.
  - JAL: jal=1.
  - LUI: lui=1.
  - AUIPC: auipc=1, alu_src=1.
REQ-011 Exit from EXECUTE:
  - BRANCH: pc_write=1, pc_src=01 if branch_taken else 00, instr_retired=1, next FETCH.
  - LOAD/STORE: next MEMORY.
  - All other classes: next WRITEBACK.
REQ-012 MEMORY: assert mem_req=1, mem_we=(STORE), mem_size=funct3[1:0], mem_unsigned=funct3[2]&(LOAD); hold until mem_ready.
REQ-013 MEMORY exit on mem_ready: LOAD goes to WRITEBACK; STORE asserts pc_write=1, pc_src=00, instr_retired=1 and goes to FETCH.
REQ-014 WRITEBACK (one cycle):
  - reg_write=1 (except the TRAP_ILLEGAL=0 ILLEGAL case), pc_write=1, instr_retired=1, next FETCH.
  - mem_to_reg=1 for LOAD.
  - pc_src=01 for JAL, 10 for JALR, 00 otherwise.
  - The EXECUTE selects of REQ-010 stay asserted.
REQ-015 Timeout counter:
  - Width is $clog2(MEM_TIMEOUT+1).
  - Clears on entry to FETCH or MEMORY and counts each cycle without mem_ready.
  - mem_ready in the MEM_TIMEOUT-th waiting cycle is accepted.
  - With no mem_ready by the end of that cycle, go to TRAP and set bus_error.
REQ-016 TRAP: every strobe is 0 and the state holds until reset; illegal and bus_error stay set.
REQ-017 mem_ready outside FETCH or MEMORY is ignored.
REQ-018 Every output not named for the current state and class is 0.

Reset
REQ-019 When rst_n=0 at a rising edge: state=FETCH, counter=0, illegal=0, bus_error=0, registered class=ILLEGAL/0.
REQ-020 While rst_n=0, all outputs are forced to 0 and state reads 0.
REQ-021 Reset asserted in any state, including mid-access or TRAP, aborts the access with no pc_write or reg_write; the first cycle after release is FETCH with mem_req=1.

Verification
REQ-022 ADD (opcode 0110011), mem_ready at the first FETCH cycle -> FETCH, DECODE, EXECUTE (alu_op=10), WRITEBACK (reg_write=1, pc_write=1, instr_retired=1); 4 cycles total.
REQ-023 LW (opcode 0000011, funct3=010), mem_ready delayed 3 cycles in MEMORY -> mem_size=10, mem_unsigned=0; WRITEBACK has mem_to_reg=1; exactly one instr_retired pulse.
REQ-024 BEQ with branch_taken=1, then again with 0 -> EXECUTE asserts pc_write=1 with pc_src=01, then 00; no WRITEBACK state is visited.
REQ-025 Opcode 1111111 -> TRAP_ILLEGAL=1: state=7, illegal=1, held for 10 cycles; TRAP_ILLEGAL=0: retires with reg_write=0.
REQ-026 MEM_TIMEOUT=4, mem_ready never asserted in FETCH -> TRAP after 4 waiting cycles with bus_error=1; mem_ready in waiting cycle 4 instead goes to DECODE.
REQ-027 rst_n low for one cycle during MEMORY of an SW -> mem_we drops that cycle; no retire; FETCH follows release.
